// File: rtl/wb_result_checker.sv
`default_nettype none
// ============================================================================
//  Module   : wb_result_checker
//  Purpose  : End-of-test checker that snoops the core writeback port and
//             compares final register values against a small expectation
//             table, with a RUN watchdog and a DRAIN hold-off before DONE.
//  Ports    : clk, rst_n            - clock / async active-low reset
//             start                 - begin a run (IDLE/DONE only)
//             cfg_we/idx/en/rd/val  - expectation table write (IDLE/DONE only)
//             wb_valid/wb_rd/wb_data- writeback snoop (read-only)
//             done/pass/timeout     - registered result, held until start
//             match_mask/fail_mask  - live match state / latched failures
//             cycle_cnt/retire_cnt  - RUN+DRAIN perf counters
//  Config   : WB_CHECK_PERF_EN - when defined, perf counters are built;
//             otherwise cycle_cnt/retire_cnt are tied to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module wb_result_checker #(
    parameter int XLEN           = 64,
    parameter int NUM_CHECKS     = 4,
    parameter int TIMEOUT_CYCLES = 500,
    parameter int DRAIN_CYCLES   = 10,
    parameter int CNT_W          = 32,
    localparam int c_IDX_W       = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  cfg_we,
    input  logic [c_IDX_W-1:0]    cfg_idx,
    input  logic                  cfg_en,
    input  logic [4:0]            cfg_rd,
    input  logic [XLEN-1:0]       cfg_val,
    input  logic                  wb_valid,
    input  logic [4:0]            wb_rd,
    input  logic [XLEN-1:0]       wb_data,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [NUM_CHECKS-1:0] match_mask,
    output logic [NUM_CHECKS-1:0] fail_mask,
    output logic [CNT_W-1:0]      cycle_cnt,
    output logic [CNT_W-1:0]      retire_cnt
);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_RUN   = 2'd1;
    localparam logic [1:0] c_S_DRAIN = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    localparam int c_DRN_W = (DRAIN_CYCLES > 0) ? $clog2(DRAIN_CYCLES + 1) : 1;

    logic [1:0]            r_state;
    logic [NUM_CHECKS-1:0] r_en;
    logic [4:0]            r_rd  [NUM_CHECKS];
    logic [XLEN-1:0]       r_val [NUM_CHECKS];
    logic [NUM_CHECKS-1:0] r_match;
    logic [NUM_CHECKS-1:0] r_fail;
    logic                  r_done;
    logic                  r_pass;
    logic                  r_timeout;
    logic [CNT_W-1:0]      r_timer;
    logic [c_DRN_W-1:0]    r_drain;

    logic                  w_idle_like;
    logic                  w_active;
    logic                  w_start;
    logic                  w_cfg;
    logic [NUM_CHECKS-1:0] w_hit;
    logic [NUM_CHECKS-1:0] w_match_nxt;
    logic                  w_all_match;
    logic                  w_expire;

    assign w_idle_like = (r_state == c_S_IDLE) || (r_state == c_S_DONE);
    assign w_active    = (r_state == c_S_RUN)  || (r_state == c_S_DRAIN);
    assign w_start     = start && w_idle_like;
    assign w_cfg       = cfg_we && w_idle_like && (int'(cfg_idx) < NUM_CHECKS);

    // Per-entry next match state; x0 writebacks never touch the table.
    generate
        for (genvar gi = 0; gi < NUM_CHECKS; gi++) begin : g_entry
            assign w_hit[gi] = w_active && wb_valid && (wb_rd != 5'd0) &&
                               r_en[gi] && (r_rd[gi] == wb_rd);
            assign w_match_nxt[gi] = w_hit[gi] ? (wb_data == r_val[gi]) : r_match[gi];
        end
    endgenerate

    // Disabled entries count as satisfied.
    assign w_all_match = &(w_match_nxt | ~r_en);
    assign w_expire    = (r_timer == CNT_W'(TIMEOUT_CYCLES - 1));

    // Expectation table
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en <= '0;
            for (int i = 0; i < NUM_CHECKS; i++) begin
                r_rd[i]  <= '0;
                r_val[i] <= '0;
            end
        end else if (w_cfg) begin
            r_en[cfg_idx]  <= cfg_en;
            r_rd[cfg_idx]  <= cfg_rd;
            r_val[cfg_idx] <= cfg_val;
        end
    end

    // Run control FSM with registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= c_S_IDLE;
            r_match   <= '0;
            r_fail    <= '0;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_timeout <= 1'b0;
            r_timer   <= '0;
            r_drain   <= '0;
        end else begin
            case (r_state)
                c_S_IDLE, c_S_DONE: begin
                    if (w_start) begin
                        r_match   <= '0;
                        r_fail    <= '0;
                        r_done    <= 1'b0;
                        r_pass    <= 1'b0;
                        r_timeout <= 1'b0;
                        r_timer   <= '0;
                        r_drain   <= '0;
                        // Empty table is a vacuous pass: skip straight to DRAIN.
                        r_state   <= (|r_en) ? c_S_RUN : c_S_DRAIN;
                    end
                end
                c_S_RUN: begin
                    r_match <= w_match_nxt;
                    r_timer <= r_timer + CNT_W'(1);
                    // Matching takes priority over a same-cycle expiry.
                    if (w_all_match) begin
                        r_drain <= '0;
                        r_state <= c_S_DRAIN;
                    end else if (w_expire) begin
                        r_done    <= 1'b1;
                        r_timeout <= 1'b1;
                        r_pass    <= 1'b0;
                        r_fail    <= r_en & ~w_match_nxt;
                        r_state   <= c_S_DONE;
                    end
                end
                c_S_DRAIN: begin
                    // Keep snooping so a late overwrite can still spoil a match.
                    r_match <= w_match_nxt;
                    if (r_drain == c_DRN_W'(DRAIN_CYCLES)) begin
                        r_done  <= 1'b1;
                        r_pass  <= w_all_match;
                        r_fail  <= r_en & ~w_match_nxt;
                        r_state <= c_S_DONE;
                    end else begin
                        r_drain <= r_drain + c_DRN_W'(1);
                    end
                end
                default: r_state <= c_S_IDLE;
            endcase
        end
    end

    assign done       = r_done;
    assign pass       = r_pass;
    assign timeout    = r_timeout;
    assign match_mask = r_match;
    assign fail_mask  = r_fail;

`ifdef WB_CHECK_PERF_EN
    logic [CNT_W-1:0] r_cycle_cnt;
    logic [CNT_W-1:0] r_retire_cnt;

    // Saturating counters over RUN+DRAIN; retire counts x0 writebacks too.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else if (w_start) begin
            r_cycle_cnt  <= '0;
            r_retire_cnt <= '0;
        end else if (w_active) begin
            if (r_cycle_cnt != '1)
                r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
            if (wb_valid && (r_retire_cnt != '1))
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
        end
    end

    assign cycle_cnt  = r_cycle_cnt;
    assign retire_cnt = r_retire_cnt;
`else
    assign cycle_cnt  = '0;
    assign retire_cnt = '0;
`endif

endmodule
`default_nettype wire
